// File: rtl/mul_rs_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// mul_rs_dispatch_pkg: shared constants and entry layout for the MUL/DIV RS
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mul_rs_dispatch_pkg;

  localparam int DEPTH = 3;
  localparam int IW    = 3;
  localparam int DW    = 8;
  localparam int TAGW  = 3;
  localparam int FW    = 4;
  localparam int RDW   = 4;

  localparam logic [FW-1:0] FUNC_MUL = 4'b0010;
  localparam logic [FW-1:0] FUNC_DIV = 4'b0011;

  typedef struct packed {
    logic            busy;
    logic            sent;
    logic [FW-1:0]   func;
    logic [RDW-1:0]  rd;
    logic [TAGW-1:0] rob;
    logic            j_rdy;
    logic [DW-1:0]   j_val;
    logic [TAGW-1:0] j_tag;
    logic            k_rdy;
    logic [DW-1:0]   k_val;
    logic [TAGW-1:0] k_tag;
  } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/rs_pick_lowest.sv
// ---------------------------------------------------------------------------
// rs_pick_lowest: priority encoder returning the lowest set request index
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs_pick_lowest
  import mul_rs_dispatch_pkg::*;
#(
  parameter int N = DEPTH
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Scan downwards so the lowest requester is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_rs_dispatch.sv
// ---------------------------------------------------------------------------
// mul_rs_dispatch: MUL/DIV reservation station feeding the unpipelined exec unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_rs_dispatch
  import mul_rs_dispatch_pkg::*;
(
  input  logic            clk1,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [FW-1:0]   iss_func,
  input  logic [RDW-1:0]  iss_rd,
  input  logic [TAGW-1:0] iss_rob,
  input  logic            iss_j_rdy,
  input  logic [DW-1:0]   iss_j_val,
  input  logic [TAGW-1:0] iss_j_tag,
  input  logic            iss_k_rdy,
  input  logic [DW-1:0]   iss_k_val,
  input  logic [TAGW-1:0] iss_k_tag,
  input  logic            cdb_valid,
  input  logic [TAGW-1:0] cdb_tag,
  input  logic [15:0]     cdb_data,
  output logic            ex_b,
  output logic [DW-1:0]   rs1_data,
  output logic [DW-1:0]   rs2_data,
  output logic [FW-1:0]   func,
  output logic [RDW-1:0]  rd,
  output logic [TAGW-1:0] rob_ind,
  output logic [IW-1:0]   rs_index,
  input  logic            ex_done,
  input  logic [IW-1:0]   ex_done_idx,
  output logic [1:0]      mulcount
);

  rs_entry_t rs_q [DEPTH];
  rs_entry_t rs_d [DEPTH];
  rs_entry_t sel;

  logic            exec_free_q;
  logic            ex_b_q;
  logic [DW-1:0]   rs1_q, rs2_q;
  logic [FW-1:0]   func_q;
  logic [RDW-1:0]  rd_q;
  logic [TAGW-1:0] rob_q;
  logic [IW-1:0]   idx_q;
  logic [1:0]      mulcount_q, mulcount_d;

  logic [DEPTH-1:0] free_v, rdy_v, done_hit;
  logic             free_ok, rdy_ok;
  logic [IW-1:0]    free_idx, rdy_idx;
  logic             do_issue, do_disp, do_done;
  logic             unused_cdb_hi;

  assign unused_cdb_hi = ^cdb_data[15:DW];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_v[i]   = !rs_q[i].busy;
      rdy_v[i]    = rs_q[i].busy && !rs_q[i].sent && rs_q[i].j_rdy && rs_q[i].k_rdy;
      // Only an in-flight entry can be retired; stray completions fall through.
      done_hit[i] = ex_done && (ex_done_idx == IW'(i)) && rs_q[i].busy && rs_q[i].sent;
    end
  end

  rs_pick_lowest #(.N(DEPTH)) u_pick_free (
    .req_i   (free_v),
    .valid_o (free_ok),
    .idx_o   (free_idx)
  );

  rs_pick_lowest #(.N(DEPTH)) u_pick_ready (
    .req_i   (rdy_v),
    .valid_o (rdy_ok),
    .idx_o   (rdy_idx)
  );

  assign iss_ready = free_ok;
  assign do_issue  = iss_valid && free_ok;
  assign do_disp   = exec_free_q && rdy_ok;
  assign do_done   = |done_hit;

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_idx == IW'(i)) sel = rs_q[i];
    end
  end

  always_comb begin
    mulcount_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_d[i] = rs_q[i];
      if (cdb_valid && rs_q[i].busy) begin
        if (!rs_q[i].j_rdy && (rs_q[i].j_tag == cdb_tag)) begin
          rs_d[i].j_rdy = 1'b1;
          rs_d[i].j_val = cdb_data[DW-1:0];
        end
        if (!rs_q[i].k_rdy && (rs_q[i].k_tag == cdb_tag)) begin
          rs_d[i].k_rdy = 1'b1;
          rs_d[i].k_val = cdb_data[DW-1:0];
        end
      end
      if (do_disp && (rdy_idx == IW'(i))) rs_d[i].sent = 1'b1;
      if (done_hit[i]) begin
        rs_d[i].busy = 1'b0;
        rs_d[i].sent = 1'b0;
      end
      // Issue targets a free slot, so it never collides with wakeup or retire.
      if (do_issue && (free_idx == IW'(i))) begin
        rs_d[i].busy  = 1'b1;
        rs_d[i].sent  = 1'b0;
        rs_d[i].func  = iss_func;
        rs_d[i].rd    = iss_rd;
        rs_d[i].rob   = iss_rob;
        rs_d[i].j_tag = iss_j_tag;
        rs_d[i].k_tag = iss_k_tag;
        rs_d[i].j_rdy = iss_j_rdy || (cdb_valid && (cdb_tag == iss_j_tag));
        rs_d[i].j_val = iss_j_rdy ? iss_j_val : cdb_data[DW-1:0];
        rs_d[i].k_rdy = iss_k_rdy || (cdb_valid && (cdb_tag == iss_k_tag));
        rs_d[i].k_val = iss_k_rdy ? iss_k_val : cdb_data[DW-1:0];
      end
      mulcount_d = mulcount_d + 2'(rs_d[i].busy);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rs_q[i] <= '0;
      exec_free_q <= 1'b1;
      ex_b_q      <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      func_q      <= '0;
      rd_q        <= '0;
      rob_q       <= '0;
      idx_q       <= '0;
      mulcount_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) rs_q[i] <= rs_d[i];
      ex_b_q     <= do_disp;
      mulcount_q <= mulcount_d;
      if (do_disp) begin
        exec_free_q <= 1'b0;
        rs1_q       <= sel.j_val;
        rs2_q       <= sel.k_val;
        func_q      <= sel.func;
        rd_q        <= sel.rd;
        rob_q       <= sel.rob;
        idx_q       <= rdy_idx;
      end else if (do_done) begin
        exec_free_q <= 1'b1;
      end
    end
  end

  assign ex_b     = ex_b_q;
  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign func     = func_q;
  assign rd       = rd_q;
  assign rob_ind  = rob_q;
  assign rs_index = idx_q;
  assign mulcount = mulcount_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_rs_dispatch.sv
// ---------------------------------------------------------------------------
// tb_mul_rs_dispatch: directed bench with a dispatch scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mul_rs_dispatch;
  import mul_rs_dispatch_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic        iss_valid = 1'b0;
  logic        iss_ready;
  logic [3:0]  iss_func = '0;
  logic [3:0]  iss_rd = '0;
  logic [2:0]  iss_rob = '0;
  logic        iss_j_rdy = 1'b0;
  logic [7:0]  iss_j_val = '0;
  logic [2:0]  iss_j_tag = '0;
  logic        iss_k_rdy = 1'b0;
  logic [7:0]  iss_k_val = '0;
  logic [2:0]  iss_k_tag = '0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        ex_b;
  logic [7:0]  rs1_data, rs2_data;
  logic [3:0]  func, rd;
  logic [2:0]  rob_ind, rs_index;
  logic        ex_done = 1'b0;
  logic [2:0]  ex_done_idx = '0;
  logic [1:0]  mulcount;

  typedef struct {
    logic [7:0] rs1;
    logic [7:0] rs2;
    logic [3:0] fn;
    logic [3:0] rdst;
    logic [2:0] rob;
    logic [2:0] idx;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic inflight = 1'b0;

  always #5 clk1 = ~clk1;

  mul_rs_dispatch dut (
    .clk1(clk1), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_j_rdy(iss_j_rdy), .iss_j_val(iss_j_val), .iss_j_tag(iss_j_tag),
    .iss_k_rdy(iss_k_rdy), .iss_k_val(iss_k_val), .iss_k_tag(iss_k_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_b(ex_b), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rd(rd), .rob_ind(rob_ind), .rs_index(rs_index),
    .ex_done(ex_done), .ex_done_idx(ex_done_idx), .mulcount(mulcount)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                      input logic [3:0] d, input logic [2:0] r, input logic [2:0] x);
    exp_t e;
    e.rs1 = a; e.rs2 = b; e.fn = f; e.rdst = d; e.rob = r; e.idx = x;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [2:0] r,
                       input logic jr, input logic [7:0] jv, input logic [2:0] jt,
                       input logic kr, input logic [7:0] kv, input logic [2:0] kt);
    iss_valid = 1'b1; iss_func = f; iss_rd = d; iss_rob = r;
    iss_j_rdy = jr; iss_j_val = jv; iss_j_tag = jt;
    iss_k_rdy = kr; iss_k_val = kv; iss_k_tag = kt;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] dat);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = dat;
  endtask

  task automatic done(input logic [2:0] idx);
    ex_done = 1'b1; ex_done_idx = idx; inflight = 1'b0;
  endtask

  // One clock: sample after the edge, drop one-shot inputs, score any dispatch.
  task automatic tick();
    exp_t e;
    @(posedge clk1);
    #1;
    iss_valid = 1'b0; cdb_valid = 1'b0; ex_done = 1'b0;
    if (ex_b) begin
      chk("exb_while_inflight", {15'd0, inflight}, 16'd0);
      inflight = 1'b1;
      chk("exb_expected", {15'd0, sbq.size() != 0}, 16'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("disp_rs1", {8'd0, rs1_data}, {8'd0, e.rs1});
        chk("disp_rs2", {8'd0, rs2_data}, {8'd0, e.rs2});
        chk("disp_func", {12'd0, func}, {12'd0, e.fn});
        chk("disp_rd", {12'd0, rd}, {12'd0, e.rdst});
        chk("disp_rob", {13'd0, rob_ind}, {13'd0, e.rob});
        chk("disp_idx", {13'd0, rs_index}, {13'd0, e.idx});
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk1);
    #1;
    chk("rst_exb", {15'd0, ex_b}, 16'd0);
    chk("rst_rs1", {8'd0, rs1_data}, 16'd0);
    chk("rst_func", {12'd0, func}, 16'd0);
    chk("rst_cnt", {14'd0, mulcount}, 16'd0);
    chk("rst_ready", {15'd0, iss_ready}, 16'd1);
    rst = 1'b0;

    // MUL 3*5, both sources ready
    issue(FUNC_MUL, 4'd1, 3'd1, 1'b1, 8'd3, 3'd0, 1'b1, 8'd5, 3'd0);
    push(8'd3, 8'd5, FUNC_MUL, 4'd1, 3'd1, 3'd0);
    tick();
    chk("t1_exb_lat", {15'd0, ex_b}, 16'd0);
    chk("t1_cnt", {14'd0, mulcount}, 16'd1);
    tick();
    chk("t1_exb", {15'd0, ex_b}, 16'd1);
    tick();
    chk("t1_exb_pulse", {15'd0, ex_b}, 16'd0);
    chk("t1_hold_rs1", {8'd0, rs1_data}, 16'd3);
    done(3'd0);
    tick();
    chk("t1_cnt_free", {14'd0, mulcount}, 16'd0);

    // DIV waiting on tag 4
    issue(FUNC_DIV, 4'd2, 3'd2, 1'b0, 8'hEE, 3'd4, 1'b1, 8'd2, 3'd0);
    tick();
    tick();
    chk("t2_wait", {15'd0, ex_b}, 16'd0);
    cdb(3'd4, 16'h3412);
    push(8'h12, 8'd2, FUNC_DIV, 4'd2, 3'd2, 3'd0);
    tick();
    chk("t2_wake_lat", {15'd0, ex_b}, 16'd0);
    tick();
    chk("t2_exb", {15'd0, ex_b}, 16'd1);
    done(3'd0);
    tick();

    // Issue-cycle CDB bypass
    issue(FUNC_MUL, 4'd3, 3'd3, 1'b0, 8'hAA, 3'd2, 1'b1, 8'd9, 3'd0);
    cdb(3'd2, 16'h0007);
    push(8'd7, 8'd9, FUNC_MUL, 4'd3, 3'd3, 3'd0);
    tick();
    tick();
    chk("t3_exb", {15'd0, ex_b}, 16'd1);
    done(3'd0);
    tick();

    // Fill all entries, drop a fourth issue
    issue(FUNC_MUL, 4'd4, 3'd4, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
    push(8'd1, 8'd1, FUNC_MUL, 4'd4, 3'd4, 3'd0);
    tick();
    issue(FUNC_DIV, 4'd5, 3'd5, 1'b0, 8'd0, 3'd7, 1'b1, 8'd2, 3'd0);
    tick();
    issue(FUNC_MUL, 4'd6, 3'd6, 1'b0, 8'd0, 3'd7, 1'b1, 8'd3, 3'd0);
    tick();
    chk("t4_full_cnt", {14'd0, mulcount}, 16'd3);
    chk("t4_full_ready", {15'd0, iss_ready}, 16'd0);
    issue(FUNC_MUL, 4'd7, 3'd7, 1'b1, 8'd4, 3'd0, 1'b1, 8'd4, 3'd0);
    tick();
    chk("t4_drop_cnt", {14'd0, mulcount}, 16'd3);
    done(3'd0);
    issue(FUNC_MUL, 4'd7, 3'd7, 1'b1, 8'd4, 3'd0, 1'b1, 8'd4, 3'd0);
    chk("t4_sameclk_ready", {15'd0, iss_ready}, 16'd0);
    tick();
    chk("t4_free_cnt", {14'd0, mulcount}, 16'd2);
    chk("t4_free_ready", {15'd0, iss_ready}, 16'd1);

    // Two entries woken together: lowest first, second waits for completion
    cdb(3'd7, 16'h0021);
    push(8'h21, 8'd2, FUNC_DIV, 4'd5, 3'd5, 3'd1);
    push(8'h21, 8'd3, FUNC_MUL, 4'd6, 3'd6, 3'd2);
    tick();
    tick();
    chk("t5_first_exb", {15'd0, ex_b}, 16'd1);
    repeat (3) begin
      tick();
      chk("t5_held", {15'd0, ex_b}, 16'd0);
    end
    chk("t5_idx_hold", {13'd0, rs_index}, 16'd1);
    done(3'd1);
    tick();
    chk("t5_done_lat", {15'd0, ex_b}, 16'd0);
    tick();
    chk("t5_second_exb", {15'd0, ex_b}, 16'd1);
    done(3'd0);
    inflight = 1'b1;
    tick();
    chk("t5_stray_done_cnt", {14'd0, mulcount}, 16'd1);

    // Reset with one op in flight and one waiting
    issue(FUNC_DIV, 4'd8, 3'd7, 1'b1, 8'd6, 3'd0, 1'b1, 8'd3, 3'd0);
    tick();
    chk("t6_pre_cnt", {14'd0, mulcount}, 16'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_exb", {15'd0, ex_b}, 16'd0);
    chk("t6_rst_rs1", {8'd0, rs1_data}, 16'd0);
    chk("t6_rst_rs2", {8'd0, rs2_data}, 16'd0);
    chk("t6_rst_idx", {13'd0, rs_index}, 16'd0);
    chk("t6_rst_rob", {13'd0, rob_ind}, 16'd0);
    chk("t6_rst_cnt", {14'd0, mulcount}, 16'd0);
    #1;
    rst = 1'b0;
    inflight = 1'b0;
    done(3'd2);
    tick();
    chk("t6_late_done_cnt", {14'd0, mulcount}, 16'd0);
    done(3'd0);
    tick();
    chk("t6_late_done_exb", {15'd0, ex_b}, 16'd0);
    chk("t6_ready", {15'd0, iss_ready}, 16'd1);

    // Exec unit free again after reset
    issue(FUNC_MUL, 4'd7, 3'd1, 1'b1, 8'h40, 3'd0, 1'b1, 8'h02, 3'd0);
    push(8'h40, 8'h02, FUNC_MUL, 4'd7, 3'd1, 3'd0);
    tick();
    tick();
    chk("t7_exb", {15'd0, ex_b}, 16'd1);
    chk("sb_drained", sbq.size()[15:0], 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
